// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, address-error codes and
// the enums used by the bus FSM and the alignment/formatting logic.
package mem_stage_pkg;

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [5:0] EXC_ADEL = 6'b100100;
    localparam logic [5:0] EXC_ADES = 6'b100101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;
    typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_t;

    function automatic logic is_load(input logic [5:0] ic);
        return ic inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [5:0] ic);
        return ic inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic mem_size_t mem_size(input logic [5:0] ic);
        case (ic)
            OP_LB, OP_LBU, OP_SB: return MEM_BYTE;
            OP_LH, OP_LHU, OP_SH: return MEM_HALF;
            default:              return MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
// A request is offered while dreq_valid=1 with addr/strobe/data held stable
// until dresp_addr_ok accepts it; dresp_data_ok (same cycle or later) ends it.
interface mem_stage_if;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_align.sv
// Combinational alignment check, store lane steering and load formatting.
// addr is only the byte offset within the word; the upper bits never matter here.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  icode,
    input  logic [1:0]  addr,
    input  logic [31:0] valt,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  strobe,
    output logic [31:0] wdata,
    output logic [31:0] rdata_fmt,
    output logic        adel,
    output logic        ades
);
    mem_size_t   size;
    logic        misaligned;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign size       = mem_size(icode);
    assign misaligned = ((size == MEM_WORD) && (addr != 2'b00)) ||
                        ((size == MEM_HALF) && addr[0]);
    assign adel       = is_load(icode) && misaligned;
    assign ades       = is_store(icode) && misaligned;
    assign half_l     = addr[1] ? rdata_raw[31:16] : rdata_raw[15:0];

    always_comb begin
        case (addr)
            2'd0:    byte_l = rdata_raw[7:0];
            2'd1:    byte_l = rdata_raw[15:8];
            2'd2:    byte_l = rdata_raw[23:16];
            default: byte_l = rdata_raw[31:24];
        endcase
    end

    always_comb begin
        strobe = 4'b0000;
        wdata  = valt;
        if (is_store(icode)) begin
            case (size)
                MEM_BYTE: begin strobe = 4'b0001 << addr; wdata = {4{valt[7:0]}};  end
                MEM_HALF: begin strobe = 4'b0011 << addr; wdata = {2{valt[15:0]}}; end
                default:  strobe = 4'b1111;
            endcase
        end
    end

    always_comb begin
        rdata_fmt = rdata_raw;
        case (icode)
            OP_LB:   rdata_fmt = {{24{byte_l[7]}}, byte_l};
            OP_LBU:  rdata_fmt = {24'b0, byte_l};
            OP_LH:   rdata_fmt = {{16{half_l[15]}}, half_l};
            OP_LHU:  rdata_fmt = {16'b0, half_l};
            default: rdata_fmt = rdata_raw;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: E->M pipeline register, address-error detection,
// data bus transaction FSM and load data formatting for writeback.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic [31:0] M_pc,
    input  logic [31:0] M_val3,
    input  logic [31:0] M_valt,
    input  logic [5:0]  M_icode,
    input  logic [5:0]  M_acode,
    input  logic [5:0]  M_excCode,
    input  logic [4:0]  M_dst,
    input  logic        M_inDelaySlot,
    mem_stage_if.master dbus,
    output logic [31:0] m_pc,
    output logic [31:0] m_val3,
    output logic [5:0]  m_icode,
    output logic [5:0]  m_acode,
    output logic [5:0]  m_excCode,
    output logic [4:0]  m_dst,
    output logic        m_inDelaySlot,
    output logic [31:0] m_badvaddr,
    output logic        m_busy,
    output mem_state_t  dbg_state
);
    logic [31:0] r_val3, r_valt, rdata;
    logic [4:0]  r_dst;
    mem_state_t  state, state_nx;
    logic        load_en, bubble_en, capture;
    logic [5:0]  exc_new, al_icode;
    logic [31:0] bad_new, al_valt, al_wdata, al_rdata;
    logic [1:0]  al_off;
    logic [3:0]  al_strobe;
    logic        al_adel, al_ades;

    assign m_busy    = (state == REQ) || (state == WAIT);
    assign load_en   = !m_busy && !M_stall && !M_bubble;
    assign bubble_en = !m_busy && !M_stall && M_bubble;
    assign capture   = ((state == REQ) && dbus.dresp_addr_ok && dbus.dresp_data_ok) ||
                       ((state == WAIT) && dbus.dresp_data_ok);

    // Busy: steer/format the held instruction. Idle: check the incoming one.
    assign al_icode = m_busy ? m_icode     : M_icode;
    assign al_off   = m_busy ? r_val3[1:0] : M_val3[1:0];
    assign al_valt  = m_busy ? r_valt      : M_valt;

    mem_align u_align (
        .icode     (al_icode),
        .addr      (al_off),
        .valt      (al_valt),
        .rdata_raw (dbus.dresp_data),
        .strobe    (al_strobe),
        .wdata     (al_wdata),
        .rdata_fmt (al_rdata),
        .adel      (al_adel),
        .ades      (al_ades)
    );

    always_comb begin
        exc_new = M_excCode;
        bad_new = '0;
        if (!M_excCode[5] && (al_adel || al_ades)) begin
            exc_new = al_adel ? EXC_ADEL : EXC_ADES;
            bad_new = M_val3;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pc <= '0; r_val3 <= '0; r_valt <= '0; m_icode <= '0; m_acode <= '0;
            m_excCode <= '0; r_dst <= '0; m_inDelaySlot <= 1'b0; m_badvaddr <= '0;
        end else if (load_en) begin
            m_pc <= M_pc; r_val3 <= M_val3; r_valt <= M_valt; m_icode <= M_icode;
            m_acode <= M_acode; m_excCode <= exc_new; r_dst <= M_dst;
            m_inDelaySlot <= M_inDelaySlot; m_badvaddr <= bad_new;
        end else if (bubble_en) begin
            r_val3 <= '0; r_valt <= '0; m_icode <= '0; m_acode <= '0;
            m_excCode <= '0; r_dst <= '0; m_inDelaySlot <= 1'b0; m_badvaddr <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      rdata <= '0;
        else if (capture) rdata <= al_rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (load_en)
                    state_nx = ((is_load(M_icode) || is_store(M_icode)) && !exc_new[5]) ? REQ : IDLE;
                else if (bubble_en)
                    state_nx = IDLE;
            end
            REQ:     if (dbus.dresp_addr_ok) state_nx = dbus.dresp_data_ok ? DONE : WAIT;
            WAIT:    if (dbus.dresp_data_ok) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign dbus.dreq_valid  = (state == REQ);
    assign dbus.dreq_addr   = {r_val3[31:2], 2'b00};
    assign dbus.dreq_strobe = (state == REQ) ? al_strobe : 4'b0000;
    assign dbus.dreq_data   = (state == REQ) ? al_wdata : 32'h0;

    always_comb begin
        m_val3 = r_val3;
        if (is_load(m_icode))
            m_val3 = m_excCode[5] ? 32'h0 : ((state == DONE) ? rdata : r_val3);
    end

    assign m_dst     = m_excCode[5] ? 5'd0 : r_dst;
    assign dbg_state = state;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written reset/stall/bubble sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        M_stall, M_bubble, M_inDelaySlot;
    logic [31:0] M_pc, M_val3, M_valt;
    logic [5:0]  M_icode, M_acode, M_excCode;
    logic [4:0]  M_dst;
    logic [31:0] m_pc, m_val3, m_badvaddr;
    logic [5:0]  m_icode, m_acode, m_excCode;
    logic [4:0]  m_dst;
    logic        m_inDelaySlot, m_busy;
    mem_state_t  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_ctr   = 32'hBFC0_0000;

    typedef struct {
        logic [5:0]  icode;
        logic [31:0] addr, valt, rdata;
        logic [5:0]  exc;
        logic [4:0]  dst;
        int          aw, dw;
        logic [31:0] e_val3;
        logic [5:0]  e_exc;
        logic [31:0] e_bad;
        logic [4:0]  e_dst;
        logic [3:0]  e_strobe;
        logic [31:0] e_wdata;
        int          e_req, e_busy;
    } vec_t;

    vec_t       tbl[13];
    logic [5:0] op_list[9];

    mem_stage_if dbus();

    mem_stage dut (
        .clk(clk), .resetn(resetn), .M_stall(M_stall), .M_bubble(M_bubble),
        .M_pc(M_pc), .M_val3(M_val3), .M_valt(M_valt), .M_icode(M_icode),
        .M_acode(M_acode), .M_excCode(M_excCode), .M_dst(M_dst),
        .M_inDelaySlot(M_inDelaySlot), .dbus(dbus), .m_pc(m_pc), .m_val3(m_val3),
        .m_icode(m_icode), .m_acode(m_acode), .m_excCode(m_excCode), .m_dst(m_dst),
        .m_inDelaySlot(m_inDelaySlot), .m_badvaddr(m_badvaddr), .m_busy(m_busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] ic, input logic [31:0] addr, valt, rdata,
                                input logic [5:0] exc, input logic [4:0] dst, input int aw, dw,
                                input logic [31:0] e_val3, input logic [5:0] e_exc,
                                input logic [31:0] e_bad, input logic [4:0] e_dst,
                                input logic [3:0] e_strobe, input logic [31:0] e_wdata,
                                input int e_req, e_busy);
        vec_t v;
        v.icode = ic; v.addr = addr; v.valt = valt; v.rdata = rdata; v.exc = exc; v.dst = dst;
        v.aw = aw; v.dw = dw; v.e_val3 = e_val3; v.e_exc = e_exc; v.e_bad = e_bad;
        v.e_dst = e_dst; v.e_strobe = e_strobe; v.e_wdata = e_wdata; v.e_req = e_req; v.e_busy = e_busy;
        return v;
    endfunction

    // Reference model: access width in bytes, offset arithmetic, replication by multiplication.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          n, off;
        bit          ld, st;
        logic [31:0] w;
        r   = v;
        off = int'(v.addr[1:0]);
        ld  = v.icode inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        st  = v.icode inside {OP_SB, OP_SH, OP_SW};
        n   = 0;
        if (v.icode inside {OP_LB, OP_LBU, OP_SB}) n = 1;
        if (v.icode inside {OP_LH, OP_LHU, OP_SH}) n = 2;
        if (v.icode inside {OP_LW, OP_SW})         n = 4;
        r.e_exc = v.exc; r.e_bad = 0; r.e_dst = v.dst; r.e_val3 = v.addr;
        r.e_strobe = 0; r.e_wdata = 0; r.e_req = 0; r.e_busy = 0;
        if (!v.exc[5] && n != 0 && (off % n) != 0) begin
            r.e_exc = ld ? 6'h24 : 6'h25;
            r.e_bad = v.addr;
        end
        if (r.e_exc[5]) begin
            r.e_dst = 0;
            if (ld) r.e_val3 = 0;
        end else if (ld || st) begin
            r.e_req  = v.aw + 1;
            r.e_busy = v.aw + 1 + v.dw;
            if (st) begin
                r.e_strobe = 4'(((1 << n) - 1) << off);
                r.e_wdata  = (n == 1) ? 32'(v.valt[7:0]) * 32'h0101_0101 :
                             (n == 2) ? 32'(v.valt[15:0]) * 32'h0001_0001 : v.valt;
            end else begin
                w = v.rdata >> (8 * off);
                case (v.icode)
                    OP_LB:   r.e_val3 = (w[7:0] >= 8'd128) ? (32'(w[7:0]) | 32'hFFFF_FF00) : 32'(w[7:0]);
                    OP_LBU:  r.e_val3 = 32'(w[7:0]);
                    OP_LH:   r.e_val3 = (w[15:0] >= 16'd32768) ? (32'(w[15:0]) | 32'hFFFF_0000) : 32'(w[15:0]);
                    OP_LHU:  r.e_val3 = 32'(w[15:0]);
                    default: r.e_val3 = v.rdata;
                endcase
            end
        end
        return r;
    endfunction

    // Issue one instruction, act as the memory with the vector's latencies, then compare.
    task automatic apply_vec(input vec_t v, input string tag);
        int          rq, wt, cyc;
        logic        stable;
        logic [3:0]  s0;
        logic [31:0] d0, a0, exp_pc;
        logic        exp_ds;
        rq = 0; wt = 0; cyc = 0; stable = 1'b1; s0 = '0; d0 = '0; a0 = '0;
        exp_pc = pc_ctr; exp_ds = pc_ctr[2];
        M_icode = v.icode; M_val3 = v.addr; M_valt = v.valt; M_excCode = v.exc;
        M_dst = v.dst; M_acode = v.icode ^ 6'h15; M_pc = pc_ctr; M_inDelaySlot = pc_ctr[2];
        M_stall = 1'b0; M_bubble = 1'b0;
        step();
        M_stall = 1'b1;
        while (m_busy && cyc < 64) begin
            dbus.dresp_addr_ok = 1'b0;
            dbus.dresp_data_ok = 1'b0;
            dbus.dresp_data    = v.rdata;
            if (dbus.dreq_valid) begin
                if (rq == 0) begin
                    s0 = dbus.dreq_strobe; d0 = dbus.dreq_data; a0 = dbus.dreq_addr;
                end else if (s0 !== dbus.dreq_strobe || d0 !== dbus.dreq_data || a0 !== dbus.dreq_addr) begin
                    stable = 1'b0;
                end
                if (rq == v.aw) begin
                    dbus.dresp_addr_ok = 1'b1;
                    dbus.dresp_data_ok = (v.dw == 0);
                end
                rq++;
            end else begin
                if (wt == v.dw - 1) dbus.dresp_data_ok = 1'b1;
                wt++;
            end
            cyc++;
            step();
        end
        dbus.dresp_addr_ok = 1'b0;
        dbus.dresp_data_ok = 1'b0;
        check({tag, " busy_end"}, m_busy, 0);
        check({tag, " val3"}, m_val3, v.e_val3);
        check({tag, " exc"}, m_excCode, v.e_exc);
        check({tag, " badvaddr"}, m_badvaddr, v.e_bad);
        check({tag, " dst"}, m_dst, v.e_dst);
        check({tag, " icode"}, m_icode, v.icode);
        check({tag, " acode"}, m_acode, v.icode ^ 6'h15);
        check({tag, " pc"}, m_pc, exp_pc);
        check({tag, " dslot"}, m_inDelaySlot, exp_ds);
        check({tag, " req_cycles"}, rq, v.e_req);
        check({tag, " busy_cycles"}, cyc, v.e_busy);
        if (v.e_req > 0) begin
            check({tag, " dreq_addr"}, a0, {v.addr[31:2], 2'b00});
            check({tag, " dreq_stable"}, stable, 1);
            check({tag, " strobe"}, s0, v.e_strobe);
            if (v.e_strobe != 4'b0000) check({tag, " wdata"}, d0, v.e_wdata);
        end
        pc_ctr += 4;
    endtask

    initial begin
        tbl[0]  = mk(OP_LW,    32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 6'h00, 5'd5,  0, 0,
                     32'hDEAD_BEEF, 6'h00, 32'h0,         5'd5,  4'b0000, 32'h0,         1, 1);
        tbl[1]  = mk(OP_LB,    32'h1000_0003, 32'h0,         32'h80FF_0000, 6'h00, 5'd6,  0, 0,
                     32'hFFFF_FF80, 6'h00, 32'h0,         5'd6,  4'b0000, 32'h0,         1, 1);
        tbl[2]  = mk(OP_LBU,   32'h1000_0003, 32'h0,         32'h80FF_0000, 6'h00, 5'd6,  0, 0,
                     32'h0000_0080, 6'h00, 32'h0,         5'd6,  4'b0000, 32'h0,         1, 1);
        tbl[3]  = mk(OP_SH,    32'h2000_0002, 32'h1234_ABCD, 32'h0,         6'h00, 5'd0,  3, 0,
                     32'h2000_0002, 6'h00, 32'h0,         5'd0,  4'b1100, 32'hABCD_ABCD, 4, 4);
        tbl[4]  = mk(OP_LW,    32'h1000_0006, 32'h0,         32'h0,         6'h00, 5'd7,  0, 0,
                     32'h0,         6'h24, 32'h1000_0006, 5'd0,  4'b0000, 32'h0,         0, 0);
        tbl[5]  = mk(OP_SW,    32'h3000_0008, 32'h5555_0000, 32'h0,         6'h2C, 5'd9,  0, 0,
                     32'h3000_0008, 6'h2C, 32'h0,         5'd0,  4'b0000, 32'h0,         0, 0);
        tbl[6]  = mk(OP_LH,    32'h1000_0002, 32'h0,         32'h8001_7FFF, 6'h00, 5'd8,  1, 2,
                     32'hFFFF_8001, 6'h00, 32'h0,         5'd8,  4'b0000, 32'h0,         2, 4);
        tbl[7]  = mk(OP_LHU,   32'h1000_0000, 32'h0,         32'h8001_9ABC, 6'h00, 5'd10, 0, 1,
                     32'h0000_9ABC, 6'h00, 32'h0,         5'd10, 4'b0000, 32'h0,         1, 2);
        tbl[8]  = mk(OP_SB,    32'h4000_0001, 32'h0000_00A5, 32'h0,         6'h00, 5'd0,  1, 1,
                     32'h4000_0001, 6'h00, 32'h0,         5'd0,  4'b0010, 32'hA5A5_A5A5, 2, 3);
        tbl[9]  = mk(OP_SH,    32'h2000_0001, 32'h1111_2222, 32'h0,         6'h00, 5'd4,  0, 0,
                     32'h2000_0001, 6'h25, 32'h2000_0001, 5'd0,  4'b0000, 32'h0,         0, 0);
        tbl[10] = mk(OP_ADDIU, 32'h1234_5678, 32'h0,         32'h0,         6'h00, 5'd3,  0, 0,
                     32'h1234_5678, 6'h00, 32'h0,         5'd3,  4'b0000, 32'h0,         0, 0);
        tbl[11] = mk(OP_SW,    32'h3000_000C, 32'h0BAD_F00D, 32'h0,         6'h00, 5'd0,  2, 0,
                     32'h3000_000C, 6'h00, 32'h0,         5'd0,  4'b1111, 32'h0BAD_F00D, 3, 3);
        tbl[12] = mk(OP_LB,    32'h1000_0001, 32'h0,         32'h0000_7F00, 6'h00, 5'd2,  0, 0,
                     32'h0000_007F, 6'h00, 32'h0,         5'd2,  4'b0000, 32'h0,         1, 1);
        op_list = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, OP_ADDIU};

        resetn = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; M_inDelaySlot = 1'b0;
        M_pc = '0; M_val3 = '0; M_valt = '0; M_icode = '0; M_acode = FN_ADDU;
        M_excCode = '0; M_dst = '0;
        dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0; dbus.dresp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset val3", m_val3, 0);
        check("reset pc", m_pc, 0);
        check("reset exc", m_excCode, 0);
        check("reset badvaddr", m_badvaddr, 0);
        check("reset busy", m_busy, 0);
        check("reset dreq_valid", dbus.dreq_valid, 0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.icode = op_list[$urandom_range(0, 8)];
            v.addr  = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr[0] = 1'b0;
            if ($urandom_range(0, 1) != 0) v.addr[1] = 1'b0;
            v.valt  = $urandom;
            v.rdata = $urandom;
            v.dst   = 5'($urandom);
            v.exc   = ($urandom_range(0, 7) == 0) ? {1'b1, 5'($urandom)} : 6'd0;
            v.aw    = $urandom_range(0, 3);
            v.dw    = $urandom_range(0, 2);
            apply_vec(model(v), $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while waiting for data abandons the load.
        M_icode = OP_LW; M_val3 = 32'h1000_0020; M_excCode = '0; M_stall = 1'b0; M_bubble = 1'b0;
        step();
        M_stall = 1'b1;
        check("rst_wait req", dbus.dreq_valid, 1);
        dbus.dresp_addr_ok = 1'b1;
        step();
        dbus.dresp_addr_ok = 1'b0;
        check("rst_wait valid_in_wait", dbus.dreq_valid, 0);
        check("rst_wait busy_in_wait", m_busy, 1);
        check("rst_wait state", 32'(dbg_state), 32'(WAIT));
        #2 resetn = 1'b0;
        #1;
        check("rst_wait valid_drop", dbus.dreq_valid, 0);
        check("rst_wait busy_drop", m_busy, 0);
        check("rst_wait state_idle", 32'(dbg_state), 32'(IDLE));
        step();
        resetn = 1'b1;
        dbus.dresp_data_ok = 1'b1; dbus.dresp_data = 32'h7777_7777;
        step();
        dbus.dresp_data_ok = 1'b0;
        check("late_data state", 32'(dbg_state), 32'(IDLE));
        check("late_data busy", m_busy, 0);
        check("late_data val3", m_val3, 0);

        // Stall in DONE keeps the loaded value; stray data_ok is ignored.
        apply_vec(mk(OP_LW, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 6'h00, 5'd11, 0, 0,
                     32'hCAFE_F00D, 6'h00, 32'h0, 5'd11, 4'b0000, 32'h0, 1, 1), "stall_ld");
        dbus.dresp_data_ok = 1'b1; dbus.dresp_data = 32'h1111_1111;
        step();
        dbus.dresp_data_ok = 1'b0;
        check("stall_done val3_1", m_val3, 32'hCAFE_F00D);
        step();
        check("stall_done val3_2", m_val3, 32'hCAFE_F00D);
        check("stall_done state", 32'(dbg_state), 32'(DONE));
        M_icode = OP_ADDIU; M_val3 = 32'h0000_0077; M_stall = 1'b0;
        step();
        check("after_stall val3", m_val3, 32'h0000_0077);
        check("after_stall state", 32'(dbg_state), 32'(IDLE));

        // Bubble raised while busy waits for DONE, then clears all but pc.
        M_icode = OP_LW; M_val3 = 32'h1000_0010; M_pc = 32'h8000_0100; M_stall = 1'b0; M_bubble = 1'b0;
        step();
        M_bubble = 1'b1; M_icode = OP_ADDIU; M_pc = 32'h8000_0200;
        step();
        step();
        check("bubble_busy busy", m_busy, 1);
        check("bubble_busy icode", m_icode, OP_LW);
        check("bubble_busy valid", dbus.dreq_valid, 1);
        dbus.dresp_addr_ok = 1'b1; dbus.dresp_data_ok = 1'b1; dbus.dresp_data = 32'h5A5A_1234;
        step();
        dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0;
        check("bubble_done val3", m_val3, 32'h5A5A_1234);
        check("bubble_done state", 32'(dbg_state), 32'(DONE));
        step();
        check("bubble_clr icode", m_icode, 0);
        check("bubble_clr val3", m_val3, 0);
        check("bubble_clr pc", m_pc, 32'h8000_0100);
        check("bubble_clr state", 32'(dbg_state), 32'(IDLE));
        M_bubble = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
